// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone-to-BRAM bridge: FSM encoding, default
// address window and the wait-counter width.
package wb_bram_pkg;

   localparam int          DLY_W         = 8;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
   localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_ACCESS = 3'd2,
      S_RESP   = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   function automatic logic addr_hit(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
      return (adr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/wb_bram_dly_cnt.sv
// Wait-cycle counter: clear, load or increment; tc_o flags the last wait cycle
// (count == DELAYS-1).
module wb_bram_dly_cnt
   import wb_bram_pkg::*;
#(
   parameter int DELAYS = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [DLY_W-1:0] ld_val_i,
   input  logic             inc_i,
   output logic [DLY_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [DLY_W-1:0] TC_VAL = (DELAYS > 0) ? DLY_W'(DELAYS - 1) : '0;

   logic [DLY_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (ld_i) begin
         cnt_q <= ld_val_i;
      end else if (inc_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone B4 classic slave in front of a single-port 32-bit BRAM, inserting
// DELAYS wait cycles before every access to emulate slow external memory.
module wb_bram_ctrl
   import wb_bram_pkg::*;
#(
   parameter int          DELAYS    = 10,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
   parameter int          N         = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic [3:0]       bram_we,
   output logic             bram_en,
   output logic [31:0]      bram_di,
   output logic [31:0]      bram_a,
   input  logic [31:0]      bram_do,
   output logic [2:0]       dbg_state_o,
   output logic [DLY_W-1:0] dbg_cnt_o
);

   localparam bit HAS_WAIT = (DELAYS > 0);

   // Handshake: a transfer is claimed when cyc & stb & window hit are seen in
   // IDLE; exactly one single-cycle ack follows unless cyc drops first.
   state_e         state_q;
   logic           we_q;
   logic [3:0]     sel_q;
   logic [31:0]    dat_q;
   logic [N-1:0]   adr_q;
   logic           ack_q;
   logic [31:0]    rdat_q;
   logic           bram_en_q;
   logic [3:0]     bram_we_q;
   logic [31:0]    bram_di_q;
   logic [N-1:0]   bram_a_q;

   logic           hit;
   logic           cnt_clr;
   logic           cnt_inc;
   logic           cnt_tc;

   assign hit     = wbs_cyc_i & wbs_stb_i & addr_hit(wbs_adr_i, BASE_ADDR, ADDR_MASK);
   assign cnt_clr = (state_q == S_IDLE) & hit;
   assign cnt_inc = (state_q == S_WAIT);

   wb_bram_dly_cnt #(
      .DELAYS(DELAYS)
   ) u_dly_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .clr_i    (cnt_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .inc_i    (cnt_inc),
      .cnt_o    (dbg_cnt_o),
      .tc_o     (cnt_tc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         sel_q     <= '0;
         dat_q     <= '0;
         adr_q     <= '0;
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         bram_en_q <= 1'b0;
         bram_we_q <= '0;
         bram_di_q <= '0;
         bram_a_q  <= '0;
      end else begin
         // Enable, byte writes and ack are single-cycle pulses by default.
         bram_en_q <= 1'b0;
         bram_we_q <= '0;
         ack_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (hit) begin
                  we_q  <= wbs_we_i;
                  sel_q <= wbs_sel_i;
                  dat_q <= wbs_dat_i;
                  adr_q <= wbs_adr_i[N+1:2];
                  if (HAS_WAIT) begin
                     state_q <= S_WAIT;
                  end else begin
                     state_q   <= S_ACCESS;
                     bram_en_q <= 1'b1;
                     bram_a_q  <= wbs_adr_i[N+1:2];
                     bram_we_q <= wbs_we_i ? wbs_sel_i : 4'b0000;
                     bram_di_q <= wbs_dat_i;
                  end
               end
            end
            S_WAIT: begin
               if (!wbs_cyc_i) begin
                  state_q <= S_IDLE;
               end else if (cnt_tc) begin
                  state_q   <= S_ACCESS;
                  bram_en_q <= 1'b1;
                  bram_a_q  <= adr_q;
                  bram_we_q <= we_q ? sel_q : 4'b0000;
                  bram_di_q <= dat_q;
               end
            end
            S_ACCESS: begin
               state_q <= wbs_cyc_i ? S_RESP : S_IDLE;
            end
            S_RESP: begin
               // BRAM read data is valid here, one cycle after the enable.
               if (!wbs_cyc_i) begin
                  state_q <= S_IDLE;
               end else begin
                  ack_q   <= 1'b1;
                  rdat_q  <= we_q ? 32'h0 : bram_do;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = rdat_q;
   assign bram_en     = bram_en_q;
   assign bram_we     = bram_we_q;
   assign bram_di     = bram_di_q;
   assign bram_a      = {{(32-N){1'b0}}, bram_a_q};
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: one bridge with 10 wait cycles, one with none,
// each driving its own behavioural BRAM.
module tb_wb_bram_ctrl;

   logic        clk;
   logic        rst;
   int          cyc_cnt;

   logic        cyc   [2];
   logic        stb   [2];
   logic        we    [2];
   logic [3:0]  sel   [2];
   logic [31:0] adr   [2];
   logic [31:0] dat_i [2];
   logic        ack   [2];
   logic [31:0] dat_o [2];
   logic [3:0]  bwe   [2];
   logic        ben   [2];
   logic [31:0] bdi   [2];
   logic [31:0] ba    [2];
   logic [31:0] bdo   [2];
   logic [2:0]  dbg_st[2];
   logic [7:0]  dbg_cn[2];

   logic [31:0] mem [2][1024];

   int          checks;
   int          errors;
   logic [31:0] exp_q[$];

   int          en_cnt  [2];
   int          en_cyc  [2];
   logic [31:0] en_a    [2];
   logic [3:0]  en_we   [2];
   int          ack_cnt [2];
   int          ack_cyc [2];
   logic [31:0] ack_dat [2];
   int          stray_we;

   wb_bram_ctrl #(.DELAYS(10)) u_dut (
      .CLK(clk), .RST(rst),
      .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
      .wbs_adr_i(adr[0]), .wbs_dat_i(dat_i[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]),
      .bram_we(bwe[0]), .bram_en(ben[0]), .bram_di(bdi[0]), .bram_a(ba[0]), .bram_do(bdo[0]),
      .dbg_state_o(dbg_st[0]), .dbg_cnt_o(dbg_cn[0])
   );

   wb_bram_ctrl #(.DELAYS(0)) u_dut0 (
      .CLK(clk), .RST(rst),
      .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
      .wbs_adr_i(adr[1]), .wbs_dat_i(dat_i[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]),
      .bram_we(bwe[1]), .bram_en(ben[1]), .bram_di(bdi[1]), .bram_a(ba[1]), .bram_do(bdo[1]),
      .dbg_state_o(dbg_st[1]), .dbg_cnt_o(dbg_cn[1])
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // behavioural BRAM: registered read, byte writes, output 0 when disabled
   initial begin
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 1024; i++) mem[u][i] = 32'h0;
         bdo[u] = 32'h0;
      end
   end

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ben[u] === 1'b1) begin
            for (int b = 0; b < 4; b++)
               if (bwe[u][b]) mem[u][ba[u][9:0]][8*b +: 8] <= bdi[u][8*b +: 8];
            bdo[u] <= mem[u][ba[u][9:0]];
         end else begin
            bdo[u] <= 32'h0;
         end
      end
   end

   // output monitor, sampled on the falling edge
   initial begin
      stray_we = 0;
      for (int u = 0; u < 2; u++) begin
         en_cnt[u] = 0; en_cyc[u] = 0; en_a[u] = '0; en_we[u] = '0;
         ack_cnt[u] = 0; ack_cyc[u] = 0; ack_dat[u] = '0;
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ben[u] === 1'b1) begin
            en_cnt[u]++;
            en_cyc[u] = cyc_cnt;
            en_a[u]   = ba[u];
            en_we[u]  = bwe[u];
         end else if (bwe[u] !== 4'b0000) begin
            stray_we++;
         end
         if (ack[u] === 1'b1) begin
            ack_cnt[u]++;
            ack_cyc[u] = cyc_cnt;
            ack_dat[u] = dat_o[u];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic drive(input int u, input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
      cyc[u] = c; stb[u] = s; we[u] = w; adr[u] = a; dat_i[u] = d; sel[u] = bs;
   endtask

   // full transfer: expected read data queued at issue, popped at ack
   task automatic xfer(input int u, input int dly, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_d,
                       input string tag);
      int          c0, e0, k0;
      bit          seen;
      logic [31:0] want;
      @(posedge clk); #1;
      c0 = cyc_cnt; e0 = en_cnt[u]; k0 = ack_cnt[u];
      exp_q.push_back(exp_d);
      drive(u, 1'b1, 1'b1, w, a, d, s);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         if (ack_cnt[u] != k0) seen = 1'b1;
      end
      #1 drive(u, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      want = exp_q.pop_front();
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_rdata"},    ack_dat[u], want);
         chk({tag, "_ack_cyc"},  32'(ack_cyc[u]), 32'(c0 + dly + 3));
         chk({tag, "_en_cnt"},   32'(en_cnt[u] - e0), 32'd1);
         chk({tag, "_en_cyc"},   32'(en_cyc[u]), 32'(c0 + dly + 1));
         chk({tag, "_bram_a"},   en_a[u], (a >> 2) & 32'h3FF);
         chk({tag, "_bram_we"},  32'(en_we[u]), w ? 32'(s) : 32'h0);
      end
      repeat (2) @(posedge clk);
      chk({tag, "_ack_once"}, 32'(ack_cnt[u] - k0), 32'd1);
   endtask

   // hold a request that must be ignored, then confirm no activity
   task automatic no_act(input int u, input logic s, input logic [31:0] a, input int n,
                         input string tag);
      int e0, k0;
      @(posedge clk); #1;
      e0 = en_cnt[u]; k0 = ack_cnt[u];
      drive(u, 1'b1, s, 1'b0, a, 32'h0, 4'hF);
      repeat (n) @(posedge clk);
      #1 drive(u, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk({tag, "_no_en"},  32'(en_cnt[u] - e0), 32'd0);
      chk({tag, "_no_ack"}, 32'(ack_cnt[u] - k0), 32'd0);
   endtask

   initial begin : stimulus
      int          e0, k0;
      logic [31:0] word4;
      checks = 0;
      errors = 0;
      for (int u = 0; u < 2; u++) drive(u, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ack",   32'(ack[0]), 32'd0);
      chk("rst_dat",   dat_o[0], 32'h0);
      chk("rst_we",    32'(bwe[0]), 32'h0);
      chk("rst_en",    32'(ben[0]), 32'd0);
      chk("rst_di",    bdi[0], 32'h0);
      chk("rst_a",     ba[0], 32'h0);
      chk("rst_state", 32'(dbg_st[0]), 32'd0);
      chk("rst_en0",   32'(ben[1]), 32'd0);

      no_act(0, 1'b0, 32'h3800_0010, 20, "no_stb");

      xfer(0, 10, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr");
      xfer(0, 10, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, "rd");
      word4 = merge(32'hDEAD_BEEF, 32'h0000_AA00, 4'b0010);
      xfer(0, 10, 1'b1, 32'h3800_0010, 32'h0000_AA00, 4'b0010, 32'h0, "bwr");
      xfer(0, 10, 1'b0, 32'h3800_0010, 32'h0, 4'hF, word4, "brd");
      xfer(0, 10, 1'b0, 32'h3800_1010, 32'h0, 4'hF, word4, "alias");
      xfer(0, 10, 1'b1, 32'h383F_FFFC, 32'h55AA_1234, 4'hF, 32'h0, "top_wr");
      xfer(0, 10, 1'b0, 32'h383F_FFFC, 32'h0, 4'hF, 32'h55AA_1234, "top_rd");

      no_act(0, 1'b1, 32'h3000_0000, 50, "oow_low");
      no_act(0, 1'b1, 32'h3840_0000, 20, "oow_high");

      xfer(1, 0, 1'b1, 32'h3800_0020, 32'hCAFE_F00D, 4'hF, 32'h0, "d0_wr");
      xfer(1, 0, 1'b0, 32'h3800_0020, 32'h0, 4'hF, 32'hCAFE_F00D, "d0_rd");

      // cyc dropped while waiting: no access, no ack, data untouched
      @(posedge clk); #1;
      e0 = en_cnt[0]; k0 = ack_cnt[0];
      drive(0, 1'b1, 1'b1, 1'b1, 32'h3800_0010, 32'h1111_1111, 4'hF);
      repeat (5) @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (20) @(posedge clk);
      chk("abort_wait_en",  32'(en_cnt[0] - e0), 32'd0);
      chk("abort_wait_ack", 32'(ack_cnt[0] - k0), 32'd0);
      xfer(0, 10, 1'b0, 32'h3800_0010, 32'h0, 4'hF, word4, "abort_rd");

      // cyc dropped during the response cycle: access happens, ack suppressed
      @(posedge clk); #1;
      e0 = en_cnt[0]; k0 = ack_cnt[0];
      drive(0, 1'b1, 1'b1, 1'b0, 32'h3800_0010, 32'h0, 4'hF);
      repeat (12) @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (10) @(posedge clk);
      chk("abort_resp_en",  32'(en_cnt[0] - e0), 32'd1);
      chk("abort_resp_ack", 32'(ack_cnt[0] - k0), 32'd0);

      // reset during the wait of a write: write must not happen
      @(posedge clk); #1;
      e0 = en_cnt[0]; k0 = ack_cnt[0];
      drive(0, 1'b1, 1'b1, 1'b1, 32'h3800_0010, 32'h2222_2222, 4'hF);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("rst_mid_state", 32'(dbg_st[0]), 32'd0);
      chk("rst_mid_cnt",   32'(dbg_cn[0]), 32'd0);
      repeat (15) @(posedge clk);
      chk("rst_mid_en",  32'(en_cnt[0] - e0), 32'd0);
      chk("rst_mid_ack", 32'(ack_cnt[0] - k0), 32'd0);
      xfer(0, 10, 1'b0, 32'h3800_0010, 32'h0, 4'hF, word4, "rst_rd");

      chk("stray_we",  32'(stray_we), 32'd0);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
